// File: rtl/led_scan_decoder.sv
// ---------------------------------------------------------------------------
// led_scan_decoder
//
// Purpose:
//   Loop-back checker for a multiplexed, common-anode, active-low 7-segment
//   display bus. It watches the segment byte and the one-hot active-low digit
//   select, waits for each pattern to be held steadily, turns the glyph back
//   into a hex nibble and assembles one nibble per digit into a word. When
//   every digit has been seen the word is published on value_out. Glyphs
//   that are not legal hex characters raise pattern_err and discard the
//   partially assembled frame.
//
// Parameters:
//   DIGITS         number of multiplexed digits (1..8)
//   STABLE_CYCLES  identical consecutive samples needed to accept (2..255)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   seg_in       segment bus, active low; [6:0] = segments g..a, [7] = dp
//   com_in       digit select, active low one-hot; bit 0 = least significant
//   value_out    last complete word, digit i in [4i+3:4i]
//   value_valid  one-cycle pulse when value_out is reloaded
//   pattern_err  one-cycle pulse when an accepted glyph is not legal hex
// ---------------------------------------------------------------------------
module led_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg_in,
    input  logic [DIGITS-1:0]     com_in,
    output logic [4*DIGITS-1:0]   value_out,
    output logic                  value_valid,
    output logic                  pattern_err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // The accept fires on the edge where the counter steps onto
    // STABLE_CYCLES-1, so the comparison is made against the value one below.
    localparam logic [7:0] ACCEPT_COUNT = 8'(STABLE_CYCLES - 2);
    localparam logic [7:0] SAT_COUNT    = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSEMBLE = 2'd1,
        COMPLETE = 2'd2
    } stateT;

    // Synchronizer stages and the previous-sample register.
    logic [7:0]          r_segSync1;
    logic [7:0]          r_segSync2;
    logic [DIGITS-1:0]   r_comSync1;
    logic [DIGITS-1:0]   r_comSync2;
    logic [7:0]          r_segPrev;
    logic [DIGITS-1:0]   r_comPrev;
    logic [7:0]          r_stableCount;

    // Frame assembly state.
    logic [4*DIGITS-1:0] r_shadow;
    logic [DIGITS-1:0]   r_seen;
    stateT               r_state;

    logic                w_sameSample;
    logic                w_accept;
    logic [3:0]          w_zeroCount;
    logic [IDX_W-1:0]    w_digitIdx;
    logic                w_oneDigit;
    logic [4:0]          w_decoded;
    logic                w_glyphValid;
    logic [3:0]          w_nibble;
    logic [DIGITS-1:0]   w_digitMask;
    logic [DIGITS-1:0]   w_seenNext;
    logic                w_frameDone;
    logic [4*DIGITS-1:0] w_shadowMerged;

    // Inverse of the hex-to-segment encoder. Returns {legal, nibble}; any
    // pattern not in the table comes back with the legal bit clear.
    function automatic logic [4:0] decodeGlyph(input logic [6:0] glyph);
        logic [4:0] result;
        case (glyph)
            7'h40:   result = {1'b1, 4'h0};
            7'h79:   result = {1'b1, 4'h1};
            7'h24:   result = {1'b1, 4'h2};
            7'h30:   result = {1'b1, 4'h3};
            7'h19:   result = {1'b1, 4'h4};
            7'h12:   result = {1'b1, 4'h5};
            7'h02:   result = {1'b1, 4'h6};
            7'h78:   result = {1'b1, 4'h7};
            7'h00:   result = {1'b1, 4'h8};
            7'h10:   result = {1'b1, 4'h9};
            7'h08:   result = {1'b1, 4'hA};
            7'h03:   result = {1'b1, 4'hB};
            7'h46:   result = {1'b1, 4'hC};
            7'h21:   result = {1'b1, 4'hD};
            7'h06:   result = {1'b1, 4'hE};
            7'h0E:   result = {1'b1, 4'hF};
            default: result = 5'b0_0000;
        endcase
        return result;
    endfunction

    // Capture path: two synchronizer flops per input, then a copy of the
    // synchronized sample so consecutive samples can be compared. The
    // counter measures how long the current sample has been held and
    // saturates so that a long hold yields a single accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_segSync1    <= '1;
            r_segSync2    <= '1;
            r_comSync1    <= '1;
            r_comSync2    <= '1;
            r_segPrev     <= '1;
            r_comPrev     <= '1;
            r_stableCount <= '0;
        end else begin
            r_segSync1 <= seg_in;
            r_segSync2 <= r_segSync1;
            r_comSync1 <= com_in;
            r_comSync2 <= r_comSync1;
            r_segPrev  <= r_segSync2;
            r_comPrev  <= r_comSync2;
            if (!w_sameSample) begin
                r_stableCount <= '0;
            end else if (r_stableCount < SAT_COUNT) begin
                r_stableCount <= r_stableCount + 8'd1;
            end
        end
    end

    assign w_sameSample = (r_segSync2 == r_segPrev) && (r_comSync2 == r_comPrev);
    assign w_accept     = w_sameSample && (r_stableCount == ACCEPT_COUNT);

    // Count the low select bits and remember which one is low; only a
    // single low bit names a digit, blanking and overlaps are ignored.
    always_comb begin
        w_zeroCount = '0;
        w_digitIdx  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!r_comSync2[i]) begin
                w_zeroCount = w_zeroCount + 4'd1;
                w_digitIdx  = IDX_W'(i);
            end
        end
    end

    assign w_oneDigit   = (w_zeroCount == 4'd1);
    assign w_decoded    = decodeGlyph(r_segSync2[6:0]);
    assign w_glyphValid = w_decoded[4];
    assign w_nibble     = w_decoded[3:0];
    assign w_digitMask  = DIGITS'(1) << w_digitIdx;
    assign w_seenNext   = r_seen | w_digitMask;
    assign w_frameDone  = (w_seenNext == '1);

    // Shadow word with the freshly decoded nibble already in place, so a
    // completing digit is published in the same edge it is written.
    always_comb begin
        w_shadowMerged = r_shadow;
        w_shadowMerged[{w_digitIdx, 2'b00} +: 4] = w_nibble;
    end

    // Frame FSM. IDLE and ASSEMBLE track whether any digit is pending;
    // COMPLETE lasts one cycle and coincides with the value_valid pulse.
    // A legal glyph updates the shadow and seen mask, and the digit that
    // fills the mask publishes the word. An illegal glyph drops the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_seen      <= '0;
            r_shadow    <= '0;
            value_out   <= '0;
            value_valid <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            pattern_err <= 1'b0;

            case (r_state)
                IDLE:     r_state <= IDLE;
                ASSEMBLE: r_state <= ASSEMBLE;
                COMPLETE: r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase

            if (w_accept && w_oneDigit) begin
                if (w_glyphValid) begin
                    r_shadow <= w_shadowMerged;
                    if (w_frameDone) begin
                        value_out   <= w_shadowMerged;
                        value_valid <= 1'b1;
                        r_seen      <= '0;
                        r_state     <= COMPLETE;
                    end else begin
                        r_seen  <= w_seenNext;
                        r_state <= ASSEMBLE;
                    end
                end else begin
                    pattern_err <= 1'b1;
                    r_seen      <= '0;
                    r_state     <= IDLE;
                end
            end
        end
    end

endmodule

// File: doc/led_scan_decoder.md
# led_scan_decoder

Recovers hexadecimal digit values from a multiplexed, common-anode, active-low 7-segment display bus: segment byte plus one-hot active-low digit select. It inverts the team's hex-to-segment encoding table. It assembles one nibble per digit into a word and flags undecodable patterns. It sits on the display pins as a loop-back checker and lets the board self-test what the display logic drives.

## Interface
- DIGITS, 4: number of multiplexed digits. Range 1..8.
- STABLE_CYCLES, 8: consecutive identical samples required before a pattern is accepted. Range 2..255.
- clk  input  1  system clock. All logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- seg_in  input  8  segment bus, active low. Bits [6:0] are segments g..a, matching encoder bit order. Bit 7 is the decimal point and is ignored.
- com_in  input  DIGITS  digit select, active low, one-hot. com_in[0] is the least-significant digit.
- value_out  output  4*DIGITS  last completely assembled word. Digit i is in [4i+3:4i].
- value_valid  output  1  one-cycle pulse when value_out updates.
- pattern_err  output  1  one-cycle pulse when an accepted pattern is not a legal hex glyph.

## Operation
- Input capture:
  - seg_in and com_in pass through a 2-flop synchronizer. Both stages reset to all-ones (blank, no digit).
  - A register holds the previous synchronized sample.
- Stability counter:
  - Counts consecutive cycles in which the synchronized {seg,com} sample equals the previous sample. It is 8 bits wide and saturates at STABLE_CYCLES.
  - Any difference resets it to 0.
  - An accept event fires once per stable window, on the cycle the counter reaches STABLE_CYCLES-1. At that point the sample has been held for STABLE_CYCLES samples.
- At an accept event:
  - If com has exactly one bit low: decode seg[6:0], then go to the decode rules below.
  - If com is all-high (blanking) or has multiple bits low: ignore the event. No state changes.
- Decode table, seg[6:0] to nibble (hex): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
- Valid pattern:
  - Write the nibble into shadow[d], where d is the index of the low com bit.
  - Set seen[d]. If seen[d] is already set, overwrite shadow[d]; seen[d] stays set.
- Invalid pattern:
  - Pulse pattern_err.
  - Clear all seen bits, which discards the partial frame.
  - value_out is held.
- Frame completion:
  - Triggered when the write would make seen all-ones.
  - On the same edge: value_out is loaded with the shadow contents, including the nibble just written. value_valid pulses and seen clears to 0.
- FSM, 2 bits:
  - IDLE: seen==0.
  - ASSEMBLE: seen partially set.
  - COMPLETE: a single-cycle state that drives value_valid, then returns to IDLE.
  - Any pattern error from any state goes to IDLE.

## Timing
- Reset values:
  - value_out=0, value_valid=0, pattern_err=0.
  - seen=0, counter=0, FSM=IDLE.
  - Synchronizer and previous-sample registers are all-ones.
- Latency: STABLE_CYCLES+2 clk edges from a raw input change (held stable) to the shadow/value_out update, i.e. 10 cycles at defaults.
- Outputs:
  - value_valid and pattern_err are registered, exactly 1 cycle wide, and never asserted together.
  - After a window is accepted, a further accept needs an input change followed by a new stable window.
- Glitches: a change lasting fewer than STABLE_CYCLES samples never produces an accept. It only delays acceptance of the surrounding value.
- Reset asserted mid-frame: all partial state is discarded immediately (asynchronous reset). The first frame after release needs every digit again.
- Decimal point: bit 7 low with a legal glyph decodes normally.

## Test plan
- Idle after reset: hold seg_in=FF, com_in=F for 50 cycles -> value_valid and pattern_err stay 0, value_out=0000.
- Full frame: scan digits 0..3 with patterns 92, 99, B0, A4, 20 cycles each -> a single value_valid on digit 3's accept, 10 cycles after its change; value_out=2345.
- Glitch filter: during digit 1's window, drive 80 for 3 cycles, then restore 99 -> no capture of 8; frame still yields 2345.
- Illegal glyph: present FF with com_in=1101 for 20 cycles in mid-frame -> one pattern_err pulse; value_out holds; the next full scan of 8E, 86, A1, C6 yields value_out=CDEF.
- Decimal point and re-scan: digit 0 = 40 (dp lit), scanned twice before the other digits arrive as F9, F8, 88 -> value_out=A710; exactly one value_valid.
- Reset mid-frame: assert rst after digits 0–2 are captured, then scan only digit 3 -> no value_valid until all four digits are rescanned.
